pixel_prefetch_fifo: RTL and testbench

- Upstream feeder for the 24-bit pixel extraction stage.
- Fetches 32-bit framebuffer words from the memory controller in fixed-length read bursts and buffers them in a show-ahead FIFO.
- Presents the FIFO head as a pull-based word source: data, valid, and a consume strobe from downstream.
- A frame_start pulse flushes the buffer and restarts fetching at a new base address.

---
 rtl/pixel_prefetch_fifo.sv | 127 ++++++++++++
 tb/tb_pixel_prefetch_fifo.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_prefetch_fifo.sv
// Burst prefetcher feeding the 24-bit pixel extractor: fetches BURST-word reads
// into a show-ahead FIFO and restarts at a new base address on frame_start.
module pixel_prefetch_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned BURST  = 4,
  parameter int unsigned ADDR_W = 21
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     frame_start,
  input  logic [ADDR_W-1:0]        base_addr,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_ack,
  input  logic [31:0]              mem_rdata,
  input  logic                     mem_rvalid,
  output logic [31:0]              out32,
  output logic                     out_valid,
  input  logic                     strobe_out,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underrun
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned BCNT_W = $clog2(BURST) + 1;

  typedef enum logic [1:0] {IDLE, REQ, DATA, DRAIN} state_t;

  state_t              state, state_next;
  logic                enabled;
  logic                stale;
  logic [ADDR_W-1:0]   fetch_addr;
  logic [BCNT_W-1:0]   beats;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [31:0]         fifo_mem [DEPTH];
  logic                wr_en, rd_en, space_ok, last_beat;

  assign space_ok  = level <= LVL_W'(DEPTH - BURST);
  assign last_beat = mem_rvalid && (beats == BCNT_W'(BURST - 1));
  assign wr_en     = (state == DATA) && mem_rvalid && !frame_start;
  assign rd_en     = strobe_out && out_valid && !frame_start;

  assign mem_req   = (state == REQ);
  assign out_valid = (level != '0);
  assign out32     = out_valid ? fifo_mem[rd_ptr] : '0;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (enabled && !frame_start && space_ok) state_next = REQ;
      // A request is never withdrawn; a flush while waiting turns its data into drain beats.
      REQ:   if (mem_ack) state_next = (stale || frame_start) ? DRAIN : DATA;
      DATA: begin
        if (last_beat)        state_next = IDLE;
        else if (frame_start) state_next = DRAIN;
      end
      DRAIN: if (last_beat) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      enabled    <= 1'b0;
      stale      <= 1'b0;
      fetch_addr <= '0;
      mem_addr   <= '0;
      beats      <= '0;
      underrun   <= 1'b0;
    end else begin
      state <= state_next;

      if (state == REQ && mem_ack)
        beats <= '0;
      else if ((state == DATA || state == DRAIN) && mem_rvalid)
        beats <= beats + BCNT_W'(1);

      if (state == REQ) begin
        if (mem_ack)          stale <= 1'b0;
        else if (frame_start) stale <= 1'b1;
      end

      if (frame_start)
        fetch_addr <= base_addr;
      else if (state == REQ && mem_ack && !stale)
        fetch_addr <= fetch_addr + ADDR_W'(BURST);

      if (state == IDLE && state_next == REQ)
        mem_addr <= fetch_addr;

      if (frame_start)
        enabled <= 1'b1;

      if (frame_start)
        underrun <= 1'b0;
      else if (strobe_out && !out_valid)
        underrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (frame_start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({wr_en, rd_en})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) fifo_mem[wr_ptr] <= mem_rdata;
  end

endmodule

// File: tb/tb_pixel_prefetch_fifo.sv
// Directed bench for pixel_prefetch_fifo: bench acts as memory controller and
// consumer; a queue-based model is compared against the DUT every cycle.
module tb_pixel_prefetch_fifo;
  localparam int DEPTH = 16;
  localparam int BURST = 4;
  localparam int AW    = 21;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          frame_start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [31:0]   mem_rdata = '0;
  logic          mem_rvalid = 1'b0;
  logic [31:0]   out32;
  logic          out_valid;
  logic          strobe_out = 1'b0;
  logic [4:0]    level;
  logic          underrun;

  pixel_prefetch_fifo #(.DEPTH(DEPTH), .BURST(BURST), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .base_addr(base_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .out32(out32), .out_valid(out_valid),
    .strobe_out(strobe_out), .level(level), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: words a consumer must see, next fetch address, and whether the
  // outstanding burst has been invalidated by a frame_start.
  logic [31:0]   q[$];
  logic [AW-1:0] addr_m;
  bit            en_m, und_m, taint_m, inb_m;
  int            left_m;
  logic          req_prev = 1'b0;
  logic [AW-1:0] held_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    addr_m = '0; en_m = 0; und_m = 0; taint_m = 0; inb_m = 0; left_m = 0;
  endtask

  task automatic model_update(input bit fs, input logic [AW-1:0] ba, input bit acked,
                              input bit rv, input logic [31:0] rd, input bit stb, input bit rb);
    bit wr;
    wr = 0;
    if (rv && inb_m) begin
      wr = !(taint_m || fs);
      left_m--;
      if (left_m == 0) begin inb_m = 0; taint_m = 0; end
    end
    if (acked) begin
      inb_m = 1; left_m = BURST;
      if (!(taint_m || fs)) addr_m = addr_m + AW'(BURST);
    end
    if (fs && (rb || inb_m)) taint_m = 1;
    if (fs) begin
      q.delete(); addr_m = ba; en_m = 1; und_m = 0;
    end else begin
      if (stb) begin
        if (q.size() > 0) void'(q.pop_front());
        else und_m = 1;
      end
      if (wr) q.push_back(rd);
    end
  endtask

  always @(negedge clk) begin
    check("level", 32'(level), 32'(q.size()));
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("out32", out32, (q.size() != 0) ? q[0] : 32'h0);
    check("underrun", 32'(underrun), 32'(und_m));
    if (mem_req && !req_prev) begin
      check("req_addr", 32'(mem_addr), 32'(addr_m));
      check("one_outstanding", 32'(inb_m), 32'd0);
      check("req_enabled", 32'(en_m), 32'd1);
    end else if (mem_req && req_prev) begin
      check("addr_hold", 32'(mem_addr), 32'(held_addr));
    end
    req_prev  = mem_req;
    held_addr = mem_addr;
  end

  task automatic step(input bit fs, input logic [AW-1:0] ba, input bit ack,
                      input bit rv, input logic [31:0] rd, input bit stb);
    bit rb;
    rb = mem_req;
    frame_start = fs; base_addr = ba; mem_ack = ack; mem_rvalid = rv;
    mem_rdata = rd; strobe_out = stb;
    @(posedge clk);
    model_update(fs, ba, ack && rb, rv, rd, stb, rb);
    #1;
    frame_start = 0; mem_ack = 0; mem_rvalid = 0; strobe_out = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, '0, 0);
  endtask

  task automatic wait_req(input int max);
    int n;
    n = 0;
    while (!mem_req && n < max) begin
      idle(1);
      n++;
    end
    if (!mem_req) check("req_timeout", 32'(mem_req), 32'd1);
  endtask

  // fs_mode: 0 none, 1 flush in a gap cycle before beat fs_k,
  // 2 flush concurrent with beat fs_k, 3 flush in the first REQ wait cycle.
  task automatic serve(input int ack_dly, input logic [31:0] d0, input int fs_mode,
                       input int fs_k, input logic [AW-1:0] fs_ba, input bit stb);
    logic [AW-1:0] old_addr;
    old_addr = mem_addr;
    for (int i = 0; i < ack_dly; i++) begin
      step(fs_mode == 3 && i == 0, fs_ba, 0, 0, '0, 0);
      if (fs_mode == 3 && i == 0) begin
        check("req_held", 32'(mem_req), 32'd1);
        check("req_old_addr", 32'(mem_addr), 32'(old_addr));
      end
    end
    step(0, '0, 1, 0, '0, 0);
    for (int k = 0; k < BURST; k++) begin
      if (fs_mode == 1 && k == fs_k) begin
        step(1, fs_ba, 0, 0, '0, 0);
        check("flush_level", 32'(level), 32'd0);
      end
      step(fs_mode == 2 && k == fs_k, fs_ba, 0, 1, d0 + 32'(k), stb);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_out32", out32, 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    reset_n = 1'b1;

    idle(5);
    check("no_fetch_before_start", 32'(mem_req), 32'd0);

    step(0, '0, 0, 0, '0, 1);
    check("underrun_set", 32'(underrun), 32'd1);
    check("underrun_level", 32'(level), 32'd0);

    step(1, 21'h100, 0, 0, '0, 0);
    check("underrun_clear", 32'(underrun), 32'd0);
    wait_req(10);
    check("first_addr", 32'(mem_addr), 32'h100);
    idle(2);
    step(0, '0, 1, 0, '0, 0);
    step(0, '0, 0, 1, 32'hA0, 0);
    check("first_valid", 32'(out_valid), 32'd1);
    check("first_word", out32, 32'hA0);
    for (int k = 1; k < BURST; k++) step(0, '0, 0, 1, 32'hA0 + 32'(k), 0);
    for (int i = 0; i < 4; i++) begin
      check("pop_order", out32, 32'hA0 + 32'(i));
      step(0, '0, 0, 0, '0, 1);
    end
    wait_req(10);
    check("second_addr", 32'(mem_addr), 32'h104);

    // Flush while the 0x104 request is pending, then fill to capacity.
    step(1, 21'h100, 0, 0, '0, 0);
    serve(0, 32'hBB, 0, 0, '0, 0);
    check("stale_dropped", 32'(level), 32'd0);
    for (int b = 0; b < 4; b++) begin
      wait_req(10);
      check("fill_addr", 32'(mem_addr), 32'h100 + 32'(4 * b));
      serve(0, 32'hC0 + 32'(4 * b), 0, 0, '0, 0);
    end
    check("full_level", 32'(level), 32'd16);
    idle(8);
    check("full_no_req", 32'(mem_req), 32'd0);
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0, '0, 1);
    check("l13_no_req", 32'(mem_req), 32'd0);
    check("l13_level", 32'(level), 32'd13);
    step(0, '0, 0, 0, '0, 1);
    wait_req(10);
    check("refill_addr", 32'(mem_addr), 32'h110);

    serve(0, 32'hD0, 0, 0, '0, 1);
    check("rw_level_const", 32'(level), 32'd12);

    wait_req(10);
    check("next_addr", 32'(mem_addr), 32'h114);
    serve(1, 32'hE0, 1, 1, 21'h200, 0);
    check("data_flush_level", 32'(level), 32'd0);
    wait_req(10);
    check("base200_addr", 32'(mem_addr), 32'h200);

    serve(3, 32'hF0, 3, 0, 21'h300, 0);
    check("req_flush_level", 32'(level), 32'd0);
    wait_req(10);
    check("base300_addr", 32'(mem_addr), 32'h300);

    serve(0, 32'h50, 2, 2, 21'h400, 0);
    check("beat_flush_level", 32'(level), 32'd0);
    wait_req(10);
    check("base400_addr", 32'(mem_addr), 32'h400);

    step(0, '0, 1, 0, '0, 0);
    step(0, '0, 0, 1, 32'h60, 0);
    step(0, '0, 0, 1, 32'h61, 0);
    check("pre_reset_level", 32'(level), 32'd2);
    reset_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_req", 32'(mem_req), 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(6);
    check("post_rst_no_req", 32'(mem_req), 32'd0);

    step(1, 21'h1FFFFE, 0, 0, '0, 0);
    wait_req(10);
    check("wrap_base_addr", 32'(mem_addr), 32'h1FFFFE);
    serve(0, 32'h70, 0, 0, '0, 0);
    check("wrap_level", 32'(level), 32'd4);
    wait_req(10);
    check("wrap_next_addr", 32'(mem_addr), 32'h000002);
    for (int i = 0; i < 4; i++) step(0, '0, 0, 0, '0, 1);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
